// File: rtl/ultrasonic_scan_sequencer_if.sv
// Signal bundle between the scan sequencer and its controller/sensor side.
// The slave modport is the sequencer's own view; master is the environment's view.
interface ultrasonic_scan_sequencer_if;
  logic        enable;
  logic [7:0]  channel_mask;
  logic        echo;
  logic [2:0]  sel;
  logic        trig;
  logic        dist_valid;
  logic [2:0]  dist_ch;
  logic [15:0] dist_data;
  logic        dist_timeout;
  logic        scan_done;
  logic        busy;

  modport master (
    output enable, channel_mask, echo,
    input  sel, trig, dist_valid, dist_ch, dist_data, dist_timeout, scan_done, busy
  );

  modport slave (
    input  enable, channel_mask, echo,
    output sel, trig, dist_valid, dist_ch, dist_data, dist_timeout, scan_done, busy
  );
endinterface

// File: rtl/ultrasonic_scan_sequencer.sv
// Round-robin ultrasonic ranging sequencer: selects each enabled sensor in turn,
// fires a trigger pulse, times the echo in distance ticks and reports the result.
module ultrasonic_scan_sequencer #(
  parameter int unsigned SETTLE_CYCLES  = 100,
  parameter int unsigned TRIG_CYCLES    = 1000,
  parameter int unsigned TICK_CYCLES    = 5800,
  parameter int unsigned TIMEOUT_CYCLES = 3800000,
  parameter int unsigned GUARD_CYCLES   = 6000000
) (
  input  logic                          clk,
  input  logic                          reset,
  ultrasonic_scan_sequencer_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_TRIGGER, S_WAIT_RISE, S_MEASURE, S_GUARD
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_echo_meta;
  logic        r_echo_sync;
  logic        r_echo_prev;
  logic [31:0] r_phase_cnt;
  logic [31:0] r_timeout_cnt;
  logic [31:0] r_tick_cnt;
  logic [15:0] r_dist;
  logic [2:0]  r_ptr;
  logic [2:0]  r_sel;
  logic        r_dist_valid;
  logic [2:0]  r_dist_ch;
  logic [15:0] r_dist_data;
  logic        r_dist_timeout;

  logic        w_rise;
  logic        w_fall;
  logic        w_phase_end;
  logic        w_timeout_hit;
  logic        w_tick;
  logic [15:0] w_dist_inc;
  logic        w_mask_any;
  logic        w_go;
  logic [2:0]  w_first_sel;
  logic [2:0]  w_next_sel;
  logic [2:0]  w_top;

  // Lowest enabled index at or after start, wrapping 7->0; returns start if none.
  function automatic logic [2:0] f_next_enabled(input logic [7:0] mask, input logic [2:0] start);
    logic [2:0] idx;
    logic       found;
    f_next_enabled = start;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = start + 3'(k);
      if (!found && mask[idx]) begin
        f_next_enabled = idx;
        found = 1'b1;
      end
    end
  endfunction

  function automatic logic [2:0] f_highest(input logic [7:0] mask);
    f_highest = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (mask[k]) f_highest = 3'(k);
    end
  endfunction

  assign w_rise        = r_echo_sync & ~r_echo_prev;
  assign w_fall        = ~r_echo_sync & r_echo_prev;
  assign w_timeout_hit = ((r_state == S_WAIT_RISE) || (r_state == S_MEASURE)) &&
                         (r_timeout_cnt == TIMEOUT_CYCLES - 1);
  assign w_tick        = (r_tick_cnt == TICK_CYCLES - 1);
  // Includes the falling-edge cycle's own tick so a pulse of N*TICK cycles reads N.
  assign w_dist_inc    = (w_tick && (r_dist != 16'hFFFE)) ? r_dist + 16'd1 : r_dist;
  assign w_mask_any    = |bus.channel_mask;
  assign w_go          = bus.enable && w_mask_any;
  assign w_first_sel   = f_next_enabled(bus.channel_mask, r_ptr);
  assign w_next_sel    = f_next_enabled(bus.channel_mask, r_sel + 3'd1);
  assign w_top         = f_highest(bus.channel_mask);

  always_comb begin
    w_phase_end = 1'b0;
    case (r_state)
      S_SETTLE:  w_phase_end = (r_phase_cnt == SETTLE_CYCLES - 1);
      S_TRIGGER: w_phase_end = (r_phase_cnt == TRIG_CYCLES - 1);
      S_GUARD:   w_phase_end = (r_phase_cnt == GUARD_CYCLES - 1);
      default:   w_phase_end = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (w_go) w_state_next = S_SETTLE;
      S_SETTLE:    if (w_phase_end) w_state_next = S_TRIGGER;
      S_TRIGGER:   if (w_phase_end) w_state_next = S_WAIT_RISE;
      S_WAIT_RISE: begin
        if (w_timeout_hit)  w_state_next = S_GUARD;
        else if (w_rise)    w_state_next = S_MEASURE;
      end
      S_MEASURE:   if (w_timeout_hit || w_fall) w_state_next = S_GUARD;
      S_GUARD:     if (w_phase_end) w_state_next = w_go ? S_SETTLE : S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  // scan_done looks at the mask live so a pass ends against the mask in force right now.
  always_comb begin
    bus.trig      = 1'b0;
    bus.busy      = 1'b1;
    bus.scan_done = 1'b0;
    case (r_state)
      S_IDLE:    bus.busy = 1'b0;
      S_TRIGGER: bus.trig = 1'b1;
      S_GUARD:   bus.scan_done = w_phase_end && w_mask_any && (r_sel == w_top);
      default:   ;
    endcase
  end

  assign bus.sel          = r_sel;
  assign bus.dist_valid   = r_dist_valid;
  assign bus.dist_ch      = r_dist_ch;
  assign bus.dist_data    = r_dist_data;
  assign bus.dist_timeout = r_dist_timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_echo_meta    <= 1'b0;
      r_echo_sync    <= 1'b0;
      r_echo_prev    <= 1'b0;
      r_phase_cnt    <= '0;
      r_timeout_cnt  <= '0;
      r_tick_cnt     <= '0;
      r_dist         <= '0;
      r_ptr          <= '0;
      r_sel          <= '0;
      r_dist_valid   <= 1'b0;
      r_dist_ch      <= '0;
      r_dist_data    <= '0;
      r_dist_timeout <= 1'b0;
    end else begin
      r_echo_meta  <= bus.echo;
      r_echo_sync  <= r_echo_meta;
      r_echo_prev  <= r_echo_sync;
      r_dist_valid <= 1'b0;

      if (r_state != w_state_next) r_phase_cnt <= '0;
      else                         r_phase_cnt <= r_phase_cnt + 32'd1;

      if ((r_state == S_WAIT_RISE) || (r_state == S_MEASURE)) r_timeout_cnt <= r_timeout_cnt + 32'd1;
      else                                                   r_timeout_cnt <= '0;

      if (r_state == S_WAIT_RISE) begin
        r_tick_cnt <= '0;
        r_dist     <= '0;
      end else if (r_state == S_MEASURE) begin
        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 32'd1;
        r_dist     <= w_dist_inc;
      end

      if (w_timeout_hit) begin
        r_dist_valid   <= 1'b1;
        r_dist_data    <= 16'hFFFF;
        r_dist_timeout <= 1'b1;
        r_dist_ch      <= r_sel;
      end else if ((r_state == S_MEASURE) && w_fall) begin
        r_dist_valid   <= 1'b1;
        r_dist_data    <= w_dist_inc;
        r_dist_timeout <= 1'b0;
        r_dist_ch      <= r_sel;
      end

      if ((r_state == S_IDLE) && w_go) begin
        r_sel <= w_first_sel;
        r_ptr <= w_first_sel;
      end else if ((r_state == S_GUARD) && w_phase_end) begin
        r_ptr <= w_next_sel;
        if (w_go) r_sel <= w_next_sel;
      end
    end
  end

endmodule

// File: tb/tb_ultrasonic_scan_sequencer.sv
// Randomized bench for the scan sequencer against a channel-order / distance model.
module tb_ultrasonic_scan_sequencer;
  localparam int SETTLE = 3;
  localparam int TRIG   = 4;
  localparam int TICK   = 5;
  localparam int TOUT   = 200;
  localparam int GUARD  = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ultrasonic_scan_sequencer_if sif();

  ultrasonic_scan_sequencer #(
    .SETTLE_CYCLES(SETTLE), .TRIG_CYCLES(TRIG), .TICK_CYCLES(TICK),
    .TIMEOUT_CYCLES(TOUT), .GUARD_CYCLES(GUARD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(sif)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] cur_mask;
  int ptr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lowest enabled channel at or after start, wrapping around eight sensors.
  function automatic int next_en(input logic [7:0] m, input int start);
    for (int k = 0; k < 8; k++) begin
      if (m[(start + k) % 8]) return (start + k) % 8;
    end
    return start % 8;
  endfunction

  function automatic int top_en(input logic [7:0] m);
    int h = -1;
    for (int k = 0; k < 8; k++) if (m[k]) h = k;
    return h;
  endfunction

  // mode: 0 echo pulse of h cycles after d, 1 no echo, 2 echo high from trigger on, 3 rises at d and sticks
  task automatic run_channel(input int exp_ch, input int mode, input int d, input int h,
                             input logic [7:0] nm, input bit drop);
    int n;
    int c;
    int sd_at;
    bit ok;
    bit seen;
    logic [2:0] s0;
    logic [15:0] exp_data;

    n = 0;
    do begin @(negedge clk); n++; end while (sif.trig !== 1'b1 && n < 1000);
    check("settle_len", n, SETTLE + 1);
    check("sel_at_trig", {29'd0, sif.sel}, exp_ch);
    s0 = sif.sel;
    ok = 1'b1;
    if (mode == 2) sif.echo = 1'b1;

    n = 0;
    while (sif.trig === 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
      ok &= (sif.sel == s0);
    end
    check("trig_width", n, TRIG);

    c = 0;
    seen = 1'b0;
    while (c < TOUT + 50) begin
      case (mode)
        0:       sif.echo = (c >= d) && (c < d + h);
        1:       sif.echo = 1'b0;
        2:       sif.echo = 1'b1;
        default: sif.echo = (c >= d);
      endcase
      if (c == 1) sif.channel_mask = nm;
      if (c == 2 && drop) sif.enable = 1'b0;
      @(negedge clk);
      c++;
      ok &= (sif.sel == s0) && (sif.trig == 1'b0);
      if (sif.dist_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    sif.echo = 1'b0;
    check("dist_valid_seen", seen, 1);

    if (mode == 0) begin
      exp_data = (h / TICK > 65534) ? 16'hFFFE : 16'(h / TICK);
      check("result_latency", c, d + h + 3);
    end else begin
      exp_data = 16'hFFFF;
      check("timeout_latency", (c == TOUT) || (c == TOUT + 1), 1);
    end
    check("dist_ch", {29'd0, sif.dist_ch}, exp_ch);
    check("dist_data", {16'd0, sif.dist_data}, {16'd0, exp_data});
    check("dist_timeout", sif.dist_timeout, (mode != 0));
    $display("ch %0d mode %0d d %0d h %0d -> data %0h timeout %0b", exp_ch, mode, d, h,
             sif.dist_data, sif.dist_timeout);

    sd_at = (sif.scan_done === 1'b1) ? 0 : -1;
    for (int i = 1; i < GUARD; i++) begin
      @(negedge clk);
      if (i == 1) ok &= (sif.dist_valid == 1'b0);
      ok &= (sif.trig == 1'b0) && (sif.sel == s0);
      if (sif.scan_done === 1'b1) sd_at = i;
    end
    check("guard_quiet", ok, 1);
    check("dist_hold", {16'd0, sif.dist_data}, {16'd0, exp_data});
    check("scan_done_pos", sd_at, (exp_ch == top_en(nm)) ? GUARD - 1 : -1);
  endtask

  task automatic step(input int mode, input int d, input int h, input logic [7:0] nm, input bit drop);
    int ch;
    ch = next_en(cur_mask, ptr);
    run_channel(ch, mode, d, h, nm, drop);
    cur_mask = nm;
    ptr = next_en(nm, (ch + 1) % 8);
  endtask

  initial begin
    int n;
    bit ok;
    logic [7:0] m;

    reset = 1'b1;
    sif.enable = 1'b0;
    sif.channel_mask = 8'h00;
    sif.echo = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {5'd0, sif.sel, sif.trig, sif.dist_valid, sif.dist_ch, sif.dist_data,
                            sif.dist_timeout, sif.scan_done, sif.busy}, 32'd0);

    reset = 1'b0;
    cur_mask = 8'h05;
    ptr = 0;
    sif.channel_mask = cur_mask;
    sif.enable = 1'b1;
    step(0, 5, 10 * TICK, 8'h05, 1'b0);
    step(0, 3, 10 * TICK, 8'h05, 1'b0);
    step(1, 0, 0, 8'h80, 1'b0);
    step(2, 0, 0, 8'h80, 1'b0);
    step(3, 4, 0, 8'h80, 1'b0);
    step(0, 2, 1, 8'h80, 1'b0);

    for (int t = 0; t < 14; t++) begin
      m = 8'($urandom_range(1, 255));
      step(($urandom_range(0, 5) == 0) ? 1 : 0, $urandom_range(1, 20), $urandom_range(1, 60), m, 1'b0);
    end

    // Abort a measurement with reset while echo is high.
    n = 0;
    do begin @(negedge clk); n++; end while (sif.trig !== 1'b1 && n < 100);
    while (sif.trig === 1'b1 && n < 200) begin @(negedge clk); n++; end
    sif.echo = 1'b1;
    repeat (8) @(negedge clk);
    check("busy_in_measure", sif.busy, 1);
    reset = 1'b1;
    sif.echo = 1'b0;
    @(negedge clk);
    check("reset_mid_measure", {5'd0, sif.sel, sif.trig, sif.dist_valid, sif.dist_ch, sif.dist_data,
                                sif.dist_timeout, sif.scan_done, sif.busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cur_mask = 8'($urandom_range(1, 255));
    sif.channel_mask = cur_mask;
    ptr = 0;
    step(0, $urandom_range(1, 20), $urandom_range(1, 60), cur_mask, 1'b0);
    step(0, $urandom_range(1, 20), $urandom_range(1, 60), cur_mask, 1'b0);

    // Drop enable while waiting for the echo; the channel still completes.
    step(0, 10, 2 * TICK, 8'hFF, 1'b1);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ok &= (sif.busy == 1'b0) && (sif.trig == 1'b0);
    end
    check("idle_after_disable", ok, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/ultrasonic_scan_sequencer.md
ULTRASONIC_SCAN_SEQUENCER -- requirements
Module: ultrasonic_scan_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 100, cycles sel held stable before trigger.
REQ-002 Parameter TRIG_CYCLES, default 1000, trig pulse width in cycles (10 us at 100 MHz).
REQ-003 Parameter TICK_CYCLES, default 5800, clock cycles per distance LSB (1 cm at 100 MHz).
REQ-004 Parameter TIMEOUT_CYCLES, default 3800000, max cycles from trig end to echo fall.
REQ-005 Parameter GUARD_CYCLES, default 6000000, dead time after each measurement.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 enable  in  1  level; 1 = scanning permitted.
REQ-009 channel_mask  in  8  bit n = 1 includes sensor n in the scan.
REQ-010 echo  in  1  asynchronous echo from the selected sensor.
REQ-011 sel  out  3  sensor index to the 3-to-8 active-low select decoder.
REQ-012 trig  out  1  trigger pulse to the selected sensor.
REQ-013 dist_valid  out  1  one-cycle strobe, result fields valid.
REQ-014 dist_ch  out  3  channel of the current result.
REQ-015 dist_data  out  16  distance in ticks, 16'hFFFF on timeout.
REQ-016 dist_timeout  out  1  result is a timeout.
REQ-017 scan_done  out  1  one-cycle strobe at end of a full pass.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 echo SHALL pass a two-flop synchronizer; all echo edges refer to the synchronized signal (2-cycle latency).
REQ-020 States SHALL be IDLE, SETTLE, TRIGGER, WAIT_RISE, MEASURE, GUARD.
REQ-021 IDLE -> SETTLE when enable=1 and channel_mask != 0; sel loads the lowest enabled index >= current pointer, wrapping 7->0.
REQ-022 SETTLE lasts exactly SETTLE_CYCLES; trig=0; sel constant from SETTLE entry until GUARD exit.
REQ-023 TRIGGER asserts trig for exactly TRIG_CYCLES consecutive cycles, then WAIT_RISE.
REQ-024 One timeout counter SHALL start at WAIT_RISE entry and run through MEASURE; reaching TIMEOUT_CYCLES ends the measurement as a timeout.
REQ-025 WAIT_RISE -> MEASURE on synchronized echo rising edge; tick prescaler and distance counter clear on that edge.
REQ-026 In MEASURE distance increments once per TICK_CYCLES cycles, saturating at 16'hFFFE.
REQ-027 MEASURE ends on synchronized echo falling edge: next cycle dist_valid=1, dist_data=count, dist_timeout=0, dist_ch=sel.
REQ-028 On timeout (either state): next cycle dist_valid=1, dist_data=16'hFFFF, dist_timeout=1, dist_ch=sel.
REQ-029 Echo high at WAIT_RISE entry SHALL NOT count as a rising edge; only a 0->1 transition does.
REQ-030 After every result, GUARD lasts GUARD_CYCLES; echo ignored.
REQ-031 GUARD exit: pointer advances to next enabled index after sel (wrap 7->0); if enable=1 and mask != 0 -> SETTLE, else -> IDLE.
REQ-032 scan_done SHALL pulse on the GUARD exit cycle when sel was the highest enabled index in channel_mask sampled at that cycle.
REQ-033 channel_mask changes SHALL take effect only at channel selection (IDLE exit, GUARD exit); the active measurement is never aborted.
REQ-034 enable deassertion mid-measurement SHALL complete the current channel including GUARD, then go IDLE.
REQ-035 dist_data, dist_ch, dist_timeout hold their last values until the next result.

Reset
REQ-036 reset=1 SHALL force on the next edge: state IDLE, pointer 0, sel=0, trig=0, dist_valid=0, dist_data=0, dist_ch=0, dist_timeout=0, scan_done=0, busy=0, all counters and synchronizer flops 0.
REQ-037 reset SHALL take priority over all other inputs, including mid-trigger (trig drops the next cycle).

Verification
REQ-038 Mask 8'h05, echo high 58000 cycles after trig -> results ch0 then ch2, dist_data=10 each, scan_done after ch2 GUARD.
REQ-039 Mask 8'h80, echo never rises -> dist_valid with dist_data=16'hFFFF, dist_timeout=1, dist_ch=7, exactly TIMEOUT_CYCLES after trig falls (+1).
REQ-040 Echo stuck high through TIMEOUT_CYCLES -> timeout result, no saturation overflow past 16'hFFFE before it.
REQ-041 trig width measured = TRIG_CYCLES; sel stable SETTLE start through GUARD end; no trig during GUARD.
REQ-042 reset asserted in MEASURE -> next cycle all outputs at REQ-036 values; restart scans from ch0.
REQ-043 enable dropped in WAIT_RISE with mask 8'hFF -> current channel result emitted, GUARD completes, busy=0, no further trig.
